// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter unit for the single-cycle core. It holds the current
// instruction address and selects the next one. In priority order the
// sources are: trap vector, stall (hold), return (pop the return-address
// stack), call (push the link and jump), jump, taken branch, and the
// sequential increment.
//
// The return-address stack (RAS) is a circular buffer with a write pointer
// and an occupancy count. When the stack is full, a push overwrites the
// oldest entry. A pop from an empty stack is an underflow: it behaves as a
// sequential step. Both overflow and underflow set the sticky ras_err flag.
//
// This block has no valid/ready handshake. Every control input is a level
// request that is sampled on each rising edge. While stall is high, all
// requests except trap are dropped, so a requester must hold its request
// until stall deasserts.
//
// Ports
//   clk           : clock; all state updates on the rising edge
//   reset         : asynchronous reset, active low
//   stall         : hold pc and the RAS this cycle (trap still applies)
//   trap          : redirect to TRAP_ADDR
//   branch_taken  : redirect to branch_target
//   branch_target : branch destination
//   jump          : redirect to jump_target
//   call          : redirect to jump_target and push pc_plus
//   ret           : redirect to the popped RAS top
//   jump_target   : jump/call destination
//   pc            : current instruction address (registered)
//   pc_plus       : pc + INC modulo 2^ADDR_WIDTH (combinational)
//   ras_empty     : RAS holds no entries
//   ras_full      : RAS holds RAS_DEPTH entries
//   ras_err       : sticky RAS overflow/underflow flag, cleared by reset
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_ADDR = 0,
    parameter int TRAP_ADDR  = 31,
    parameter int INC        = 1,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  trap,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_err
);

    // RAS_DEPTH is a power of two, so the pointer wraps naturally at its width.
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TRAP_PC  = ADDR_WIDTH'(TRAP_ADDR);
    localparam logic [ADDR_WIDTH-1:0] INC_V    = ADDR_WIDTH'(INC);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(RAS_DEPTH);

    // State
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;

    // Next-state terms
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [PTR_W-1:0]      next_ptr;
    logic [CNT_W-1:0]      next_cnt;
    logic                  next_err;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [ADDR_WIDTH-1:0] wr_data;

    logic [PTR_W-1:0]      top_idx;
    logic [ADDR_WIDTH-1:0] ras_top;

    assign pc_plus   = pc + INC_V;
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_MAX);

    // The top of stack is the slot just below the write pointer.
    assign top_idx = wr_ptr - PTR_W'(1);
    assign ras_top = ras_mem[top_idx];

    always_comb begin
        next_pc  = pc_plus;
        next_ptr = wr_ptr;
        next_cnt = cnt;
        next_err = ras_err;
        wr_en    = 1'b0;
        wr_idx   = wr_ptr;
        wr_data  = pc_plus;

        if (trap) begin
            next_pc = TRAP_PC;
        end else if (stall) begin
            next_pc = pc;
        end else if (ret) begin
            if (ras_empty) begin
                // Underflow: step sequentially and leave the stack alone,
                // even if call is also asserted this cycle.
                next_err = 1'b1;
            end else if (call) begin
                // Return and call together: take the top and replace it
                // with the new link. The occupancy does not change.
                next_pc = ras_top;
                wr_en   = 1'b1;
                wr_idx  = top_idx;
            end else begin
                next_pc  = ras_top;
                next_ptr = top_idx;
                next_cnt = cnt - CNT_W'(1);
            end
        end else if (call) begin
            next_pc  = jump_target;
            wr_en    = 1'b1;
            next_ptr = wr_ptr + PTR_W'(1);
            // When full, the pointer advance overwrites the oldest entry.
            if (ras_full) begin
                next_err = 1'b1;
            end else begin
                next_cnt = cnt + CNT_W'(1);
            end
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            wr_ptr  <= '0;
            cnt     <= '0;
            ras_err <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc      <= next_pc;
            wr_ptr  <= next_ptr;
            cnt     <= next_cnt;
            ras_err <= next_err;
            if (wr_en) begin
                ras_mem[wr_idx] <= wr_data;
            end
        end
    end

endmodule
